// File: rtl/altram_bus_ctl.sv
// 68000 alt-RAM bus-cycle controller: quadrant/config decode, ROM shadow, TOS206 DTACK
// fix-up, SDRAM REQ/ACK handoff, bus-error timeout and fast/slow clock select.
module altram_bus_ctl #(
  parameter logic [3:0]  WIN_MASK    = 4'b0110,
  parameter logic [19:0] CFG_ADDR    = 20'hFFFE0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NWAIT       = 4,
  parameter bit          FIX_TOS206  = 1'b1,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        as_n_i,
  input  logic        uds_n_i,
  input  logic        lds_n_i,
  input  logic        rw_i,
  input  logic [2:0]  fc_i,
  input  logic [23:1] a_i,
  input  logic        dtack_ext_n_i,
  input  logic        fast_en_i,
  input  logic        ram_ack_i,
  output logic        ram_req_o,
  output logic [22:0] ram_addr_o,
  output logic        ram_we_o,
  output logic [1:0]  ram_be_o,
  output logic        dtack_n_o,
  output logic        berr_n_o,
  output logic        as_ext_n_c_o,
  output logic        slow_o,
  output logic        enable_o,
  output logic        rom_shadow_o
);

  localparam int unsigned NSYNC = 5;
  localparam int unsigned WW    = 4;
  localparam int unsigned TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned AW    = 23;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_RAMSTB, S_RAMWAIT, S_TOS, S_EXT, S_DONE
  } state_e;

  state_e                              state_q, state_d;
  logic [SYNC_STAGES-1:0][NSYNC-1:0]   sync_q;
  logic [NSYNC-1:0]                    sync_in, sync_out;
  logic                                as_s, uds_s, lds_s, rw_s, dtack_ext_s;
  logic                                as_prev_q;
  logic                                first_q, fast_ok_q;
  logic [23:1]                         addr_q, addr_d;
  logic                                rw_q, rw_d;
  logic [WW-1:0]                       wcnt_q, wcnt_d;
  logic [TW-1:0]                       tcnt_q, tcnt_d;
  logic                                abort_q, abort_d;
  logic                                ram_req_q, ram_req_d;
  logic [AW-1:0]                       ram_addr_q, ram_addr_d;
  logic                                ram_we_q, ram_we_d;
  logic [1:0]                          ram_be_q, ram_be_d;
  logic                                dtack_n_q, dtack_n_d;
  logic                                berr_n_q, berr_n_d;
  logic                                slow_q, slow_d;
  logic                                enable_q, enable_d;
  logic                                shadow_q, shadow_d;
  logic                                fall_c;
  logic                                cfg_hit_c, ram_hit_c, tos_hit_c, e_region_c;

  assign sync_in  = {as_n_i, uds_n_i, lds_n_i, rw_i, dtack_ext_n_i};
  assign sync_out = sync_q[SYNC_STAGES-1];
  assign {as_s, uds_s, lds_s, rw_s, dtack_ext_s} = sync_out;
  assign fall_c   = as_prev_q & ~as_s;

  // Raw-input decode; also used to pick the FSM branch at the AS edge.
  assign e_region_c = (a_i[23:20] == 4'hE);
  assign cfg_hit_c  = (fc_i != 3'b111) && (a_i[23:4] == CFG_ADDR);
  assign ram_hit_c  = (fc_i != 3'b111) &&
                      ((enable_q && WIN_MASK[a_i[23:22]]) || (shadow_q && e_region_c));
  assign tos_hit_c  = FIX_TOS206 && rw_s &&
                      ((e_region_c && !shadow_q) || (a_i[23:3] == 21'd0));

  assign as_ext_n_c_o = as_n_i | cfg_hit_c | ram_hit_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sync_q     <= '1;
      as_prev_q  <= 1'b1;
      first_q    <= 1'b0;
      fast_ok_q  <= 1'b0;
      addr_q     <= '0;
      rw_q       <= 1'b1;
      wcnt_q     <= '0;
      tcnt_q     <= '0;
      abort_q    <= 1'b0;
      ram_req_q  <= 1'b0;
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      ram_be_q   <= 2'b00;
      dtack_n_q  <= 1'b1;
      berr_n_q   <= 1'b1;
      slow_q     <= 1'b1;
      enable_q   <= 1'b0;
      shadow_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], sync_in};
      as_prev_q  <= as_s;
      if (!first_q) begin
        first_q   <= 1'b1;
        fast_ok_q <= fast_en_i;
      end
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      wcnt_q     <= wcnt_d;
      tcnt_q     <= tcnt_d;
      abort_q    <= abort_d;
      ram_req_q  <= ram_req_d;
      ram_addr_q <= ram_addr_d;
      ram_we_q   <= ram_we_d;
      ram_be_q   <= ram_be_d;
      dtack_n_q  <= dtack_n_d;
      berr_n_q   <= berr_n_d;
      slow_q     <= slow_d;
      enable_q   <= enable_d;
      shadow_q   <= shadow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    wcnt_d     = wcnt_q;
    tcnt_d     = tcnt_q;
    abort_d    = abort_q;
    ram_req_d  = ram_req_q;
    ram_addr_d = ram_addr_q;
    ram_we_d   = ram_we_q;
    ram_be_d   = ram_be_q;
    dtack_n_d  = dtack_n_q;
    berr_n_d   = berr_n_q;
    slow_d     = slow_q;
    enable_d   = enable_q;
    shadow_d   = shadow_q;

    unique case (state_q)
      S_IDLE: begin
        slow_d  = ~fast_ok_q;
        abort_d = 1'b0;
        wcnt_d  = '0;
        if (fall_c) begin
          addr_d = a_i;
          rw_d   = rw_s;
          if (cfg_hit_c)      state_d = S_CFG;
          else if (ram_hit_c) state_d = S_RAMSTB;
          else if (tos_hit_c) state_d = S_TOS;
          else begin
            state_d = S_EXT;
            slow_d  = 1'b1;
          end
        end
      end
      S_CFG: begin
        unique case (addr_q[3:1])
          3'd7:    shadow_d = 1'b1;
          3'd6: begin
            enable_d = 1'b0;
            shadow_d = 1'b0;
          end
          default: enable_d = 1'b1;
        endcase
        dtack_n_d = 1'b0;
        state_d   = S_DONE;
      end
      // Writes assert their data strobes late, so the request waits for them.
      S_RAMSTB: begin
        if (as_s) begin
          state_d = S_IDLE;
        end else if (!uds_s || !lds_s) begin
          ram_req_d  = 1'b1;
          ram_be_d   = {~uds_s, ~lds_s};
          ram_we_d   = ~rw_q;
          ram_addr_d = (shadow_q && addr_q[23:20] == 4'hE) ? {4'hB, addr_q[19:1]}
                                                           : AW'(addr_q);
          state_d    = S_RAMWAIT;
        end
      end
      // An SDRAM cycle in flight is never aborted; a vanished CPU cycle just gets no DTACK.
      S_RAMWAIT: begin
        if (as_s) abort_d = 1'b1;
        if (ram_ack_i) begin
          ram_req_d = 1'b0;
          if (abort_q || as_s) begin
            state_d = S_IDLE;
          end else begin
            dtack_n_d = 1'b0;
            state_d   = S_DONE;
          end
        end
      end
      S_TOS: begin
        if (as_s) begin
          state_d = S_IDLE;
        end else if (wcnt_q == WW'(NWAIT - 1)) begin
          dtack_n_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      S_EXT: begin
        if (as_s) state_d = S_IDLE;
      end
      S_DONE: begin
        if (as_s) begin
          dtack_n_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bus-error watchdog, independent of the cycle FSM.
    if (as_s) begin
      tcnt_d   = '0;
      berr_n_d = 1'b1;
    end else if (TIMEOUT != 0) begin
      if (tcnt_q == TW'(TIMEOUT)) begin
        berr_n_d = 1'b0;
      end else if (dtack_n_q && dtack_ext_s) begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end
  end

  assign ram_req_o    = ram_req_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_we_o     = ram_we_q;
  assign ram_be_o     = ram_be_q;
  assign dtack_n_o    = dtack_n_q;
  assign berr_n_o     = berr_n_q;
  assign slow_o       = slow_q;
  assign enable_o     = enable_q;
  assign rom_shadow_o = shadow_q;

endmodule

// File: tb/tb_altram_bus_ctl.sv
// Directed bench for altram_bus_ctl: config page, RAM read/write, shadow, TOS206 DTACK,
// external-cycle timeout, RAMWAIT abort and mid-cycle reset.
module tb_altram_bus_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        as_n, uds_n, lds_n, rw;
  logic [2:0]  fc;
  logic [23:1] a;
  logic        dtack_ext_n, fast_en, ram_ack;
  logic        ram_req;
  logic [22:0] ram_addr;
  logic        ram_we;
  logic [1:0]  ram_be;
  logic        dtack_n, berr_n, as_ext_n, slow, enable, rom_shadow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  altram_bus_ctl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .as_n_i        (as_n),
    .uds_n_i       (uds_n),
    .lds_n_i       (lds_n),
    .rw_i          (rw),
    .fc_i          (fc),
    .a_i           (a),
    .dtack_ext_n_i (dtack_ext_n),
    .fast_en_i     (fast_en),
    .ram_ack_i     (ram_ack),
    .ram_req_o     (ram_req),
    .ram_addr_o    (ram_addr),
    .ram_we_o      (ram_we),
    .ram_be_o      (ram_be),
    .dtack_n_o     (dtack_n),
    .berr_n_o      (berr_n),
    .as_ext_n_c_o  (as_ext_n),
    .slow_o        (slow),
    .enable_o      (enable),
    .rom_shadow_o  (rom_shadow)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_start(input logic [23:0] baddr, input logic wr, input logic ud,
                           input logic ld);
    a     = baddr[23:1];
    rw    = ~wr;
    fc    = 3'b101;
    as_n  = 1'b0;
    uds_n = ud;
    lds_n = ld;
  endtask

  task automatic bus_end();
    as_n  = 1'b1;
    uds_n = 1'b1;
    lds_n = 1'b1;
    rw    = 1'b1;
  endtask

  task automatic ack_pulse();
    ram_ack = 1'b1;
    step();
    ram_ack = 1'b0;
  endtask

  // Config write followed by a full handshake; used to set mode between scenarios.
  task automatic cfg_write(input logic [2:0] off);
    int n;
    bus_start({20'hFFFE0, off, 1'b0}, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (dtack_n !== 1'b0 && n < 20) begin step(); n++; end
    checks++;
    if (dtack_n !== 1'b0) begin
      failures++;
      $display("FAIL cfg_dtack off=%0d: dtack_n=%b required 0", off, dtack_n);
    end
    bus_end();
    step(5);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1; fc = 3'b101;
    a = '0; dtack_ext_n = 1'b1; fast_en = 1'b1; ram_ack = 1'b0;
    step(2);
    checks++; if (ram_req !== 1'b0)   begin failures++; $display("FAIL rst_req: got %b need 0", ram_req); end
    checks++; if (ram_addr !== 23'd0) begin failures++; $display("FAIL rst_addr: got %h need 0", ram_addr); end
    checks++; if (ram_we !== 1'b0 || ram_be !== 2'b00) begin failures++; $display("FAIL rst_we_be: got %b/%b need 0/00", ram_we, ram_be); end
    checks++; if (dtack_n !== 1'b1 || berr_n !== 1'b1) begin failures++; $display("FAIL rst_dtack_berr: got %b/%b need 1/1", dtack_n, berr_n); end
    checks++; if (slow !== 1'b1)      begin failures++; $display("FAIL rst_slow: got %b need 1", slow); end
    checks++; if (enable !== 1'b0 || rom_shadow !== 1'b0) begin failures++; $display("FAIL rst_en_sh: got %b/%b need 0/0", enable, rom_shadow); end
    rst_n = 1'b1;
    step(4);
    checks++; if (slow !== 1'b0)      begin failures++; $display("FAIL fast_clk: slow=%b need 0", slow); end
  endtask

  task automatic test_cfg_enable();
    int n;
    bus_start(24'hFFFE00, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (as_ext_n !== 1'b1) begin failures++; $display("FAIL cfg_as_ext: got %b need 1", as_ext_n); end
    n = 0;
    while (dtack_n !== 1'b0 && n < 20) begin step(); n++; end
    checks++; if (n != 4) begin failures++; $display("FAIL cfg_dtack_lat: got %0d cycles need 4", n); end
    checks++; if (enable !== 1'b1) begin failures++; $display("FAIL cfg_enable: got %b need 1", enable); end
    step(3);
    checks++; if (dtack_n !== 1'b0) begin failures++; $display("FAIL cfg_dtack_hold: got %b need 0", dtack_n); end
    bus_end();
    n = 0;
    while (dtack_n !== 1'b1 && n < 20) begin step(); n++; end
    checks++; if (n != 3) begin failures++; $display("FAIL cfg_dtack_release: got %0d cycles need 3", n); end
    step(3);
  endtask

  task automatic test_ram_read();
    int n;
    bus_start(24'h400000, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (as_ext_n !== 1'b1) begin failures++; $display("FAIL rd_as_ext: got %b need 1", as_ext_n); end
    n = 0;
    while (ram_req !== 1'b1 && n < 20) begin step(); n++; end
    checks++; if (n != 4) begin failures++; $display("FAIL rd_req_lat: got %0d cycles need 4", n); end
    checks++; if (ram_addr !== 23'h200000) begin failures++; $display("FAIL rd_addr: got %h need 200000", ram_addr); end
    checks++; if (ram_be !== 2'b11 || ram_we !== 1'b0) begin failures++; $display("FAIL rd_be_we: got %b/%b need 11/0", ram_be, ram_we); end
    step(2);
    checks++; if (ram_req !== 1'b1 || dtack_n !== 1'b1) begin failures++; $display("FAIL rd_wait: req=%b dtack=%b need 1/1", ram_req, dtack_n); end
    ack_pulse();
    checks++; if (ram_req !== 1'b0 || dtack_n !== 1'b0) begin failures++; $display("FAIL rd_ack: req=%b dtack=%b need 0/0", ram_req, dtack_n); end
    step(4);
    checks++; if (dtack_n !== 1'b0) begin failures++; $display("FAIL rd_dtack_hold: got %b need 0", dtack_n); end
    bus_end();
    n = 0;
    while (dtack_n !== 1'b1 && n < 20) begin step(); n++; end
    checks++; if (dtack_n !== 1'b1) begin failures++; $display("FAIL rd_release: got %b need 1", dtack_n); end
    step(3);
  endtask

  task automatic test_shadow_tos();
    int n;
    cfg_write(3'd7);
    checks++; if (rom_shadow !== 1'b1) begin failures++; $display("FAIL shadow_set: got %b need 1", rom_shadow); end
    bus_start(24'hE00010, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (ram_req !== 1'b1 && n < 20) begin step(); n++; end
    checks++; if (ram_addr !== 23'h580008) begin failures++; $display("FAIL shadow_addr: got %h need 580008", ram_addr); end
    ack_pulse();
    bus_end();
    step(6);
    cfg_write(3'd6);
    checks++; if (enable !== 1'b0 || rom_shadow !== 1'b0) begin failures++; $display("FAIL cfg_clear: got %b/%b need 0/0", enable, rom_shadow); end
    bus_start(24'h000004, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (as_ext_n !== 1'b0) begin failures++; $display("FAIL tos_as_ext: got %b need 0", as_ext_n); end
    n = 0;
    while (dtack_n !== 1'b0 && n < 30) begin step(); n++; end
    checks++; if (n != 7) begin failures++; $display("FAIL tos_lat: got %0d cycles need 7", n); end
    checks++; if (ram_req !== 1'b0) begin failures++; $display("FAIL tos_no_req: got %b need 0", ram_req); end
    bus_end();
    step(6);
  endtask

  task automatic test_byte_write();
    int n;
    cfg_write(3'd0);
    bus_start(24'h800001, 1'b1, 1'b1, 1'b1);
    step(3);
    checks++; if (ram_req !== 1'b0) begin failures++; $display("FAIL wr_early_req: got %b need 0", ram_req); end
    lds_n = 1'b0;
    n = 0;
    while (ram_req !== 1'b1 && n < 20) begin step(); n++; end
    checks++; if (n != 3) begin failures++; $display("FAIL wr_req_lat: got %0d cycles need 3", n); end
    checks++; if (ram_addr !== 23'h400000) begin failures++; $display("FAIL wr_addr: got %h need 400000", ram_addr); end
    checks++; if (ram_we !== 1'b1 || ram_be !== 2'b01) begin failures++; $display("FAIL wr_we_be: got %b/%b need 1/01", ram_we, ram_be); end
    ack_pulse();
    checks++; if (dtack_n !== 1'b0) begin failures++; $display("FAIL wr_dtack: got %b need 0", dtack_n); end
    bus_end();
    step(6);
  endtask

  task automatic test_timeout();
    int n;
    bus_start(24'hFF8800, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (as_ext_n !== 1'b0) begin failures++; $display("FAIL ext_as_ext: got %b need 0", as_ext_n); end
    step(5);
    checks++; if (slow !== 1'b1) begin failures++; $display("FAIL ext_slow: got %b need 1", slow); end
    n = 5;
    while (berr_n !== 1'b0 && n < 400) begin step(); n++; end
    checks++; if (n != 258) begin failures++; $display("FAIL berr_lat: got %0d cycles need 258", n); end
    step(3);
    checks++; if (berr_n !== 1'b0) begin failures++; $display("FAIL berr_hold: got %b need 0", berr_n); end
    bus_end();
    n = 0;
    while (berr_n !== 1'b1 && n < 20) begin step(); n++; end
    checks++; if (n != 3) begin failures++; $display("FAIL berr_release: got %0d cycles need 3", n); end
    step(3);
    checks++; if (slow !== 1'b0) begin failures++; $display("FAIL ext_slow_back: got %b need 0", slow); end
  endtask

  task automatic test_abort();
    int n;
    int dt_low;
    bus_start(24'h400000, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (ram_req !== 1'b1 && n < 20) begin step(); n++; end
    checks++; if (ram_req !== 1'b1) begin failures++; $display("FAIL ab_req: got %b need 1", ram_req); end
    bus_end();
    dt_low = 0;
    for (int i = 0; i < 6; i++) begin step(); if (dtack_n !== 1'b1) dt_low++; end
    checks++; if (ram_req !== 1'b1) begin failures++; $display("FAIL ab_req_held: got %b need 1", ram_req); end
    ack_pulse();
    checks++; if (ram_req !== 1'b0) begin failures++; $display("FAIL ab_req_drop: got %b need 0", ram_req); end
    for (int i = 0; i < 5; i++) begin step(); if (dtack_n !== 1'b1) dt_low++; end
    checks++; if (dt_low != 0) begin failures++; $display("FAIL ab_no_dtack: got %0d low cycles need 0", dt_low); end
    // Controller must be back in IDLE and serve a fresh cycle.
    bus_start(24'h400002, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (ram_req !== 1'b1 && n < 20) begin step(); n++; end
    checks++; if (ram_addr !== 23'h200001) begin failures++; $display("FAIL ab_next_addr: got %h need 200001", ram_addr); end
    ack_pulse();
    bus_end();
    step(6);
  endtask

  task automatic test_reset_mid();
    int n;
    bus_start(24'h400000, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (ram_req !== 1'b1 && n < 20) begin step(); n++; end
    rst_n = 1'b0;
    #1;
    checks++; if (ram_req !== 1'b0 || ram_addr !== 23'd0) begin failures++; $display("FAIL mid_rst_req: got %b/%h need 0/0", ram_req, ram_addr); end
    checks++; if (dtack_n !== 1'b1 || berr_n !== 1'b1 || slow !== 1'b1) begin failures++; $display("FAIL mid_rst_out: got %b/%b/%b need 1/1/1", dtack_n, berr_n, slow); end
    checks++; if (enable !== 1'b0 || rom_shadow !== 1'b0) begin failures++; $display("FAIL mid_rst_en: got %b/%b need 0/0", enable, rom_shadow); end
    bus_end();
    step(2);
    rst_n = 1'b1;
    step(5);
    checks++; if (ram_req !== 1'b0 || dtack_n !== 1'b1) begin failures++; $display("FAIL post_rst: req=%b dtack=%b need 0/1", ram_req, dtack_n); end
  endtask

  initial begin
    test_reset();
    test_cfg_enable();
    test_ram_read();
    test_shadow_tos();
    test_byte_write();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
